// File: rtl/ap_loader.sv
// ap_loader: streams A and B operand columns into an associative processor,
// fires one compute command, waits for the completion interrupt, then reads
// the result column back out over a valid/ready stream.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start; outputs quiet
// CLR0       | AP reset pulse, external column side selected
// CLR1       | AP reset pulse, internal column side selected
// LOAD_A     | accepting A words, one AP write per beat into column 0
// LOAD_B     | accepting B words, one AP write per beat into column 1
// COMPUTE    | issue latched command, raise ap_mode
// WAIT_IRQ   | hold ap_mode until a fresh irq rising edge or timeout
// READ_ISSUE | one-cycle read strobe on the internal column at count
// READ_WAIT  | wait READ_LAT cycles, then capture ap_data_out
// READ_HOLD  | present result on m_*, hold until accepted
// DONE       | one-cycle done pulse, then back to IDLE
module ap_loader #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = 9,
    parameter int READ_LAT   = 1,
    parameter int TIMEOUT    = 65535
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           cmd_in,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic [2:0]           ap_cmd,
    output logic                 ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELL_QUANT - 1);
    // Timer counts down to zero; the zero cycle is the TIMEOUT-th in WAIT_IRQ.
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LAT);

    typedef enum logic [3:0] {
        IDLE,
        CLR0,
        CLR1,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        WAIT_IRQ,
        READ_ISSUE,
        READ_WAIT,
        READ_HOLD,
        DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_count;
    logic [TMR_W-1:0]  r_timer;
    logic [LAT_W-1:0]  r_lat;
    logic [2:0]        r_cmd;
    logic              r_irq_q;

    logic w_beat;
    logic w_irq_rise;

    assign w_beat     = s_valid & s_ready;
    assign w_irq_rise = ap_state_irq & ~r_irq_q;

    // Previous irq sample, so a level already high on WAIT_IRQ entry is not an edge.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            r_irq_q <= 1'b0;
        end else begin
            r_irq_q <= ap_state_irq;
        end
    end

    // Sequencer with all outputs registered; strobes default low every cycle.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            r_state             <= IDLE;
            r_count             <= '0;
            r_timer             <= '0;
            r_lat               <= '0;
            r_cmd               <= '0;
            s_ready             <= 1'b0;
            m_valid             <= 1'b0;
            m_data              <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            ap_addr             <= '0;
            ap_data             <= '0;
            ap_rst              <= 1'b0;
            ap_mode             <= 1'b0;
            ap_cmd              <= '0;
            ap_sel_col          <= 1'b0;
            ap_sel_internal_col <= 1'b0;
            ap_write_en         <= 1'b0;
            ap_read_en          <= 1'b0;
        end else begin
            ap_write_en <= 1'b0;
            ap_read_en  <= 1'b0;
            done        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cmd               <= cmd_in;
                        r_count             <= '0;
                        err                 <= 1'b0;
                        busy                <= 1'b1;
                        ap_rst              <= 1'b1;
                        ap_sel_internal_col <= 1'b0;
                        r_state             <= CLR0;
                    end
                end
                CLR0: begin
                    ap_sel_internal_col <= 1'b1;
                    r_state             <= CLR1;
                end
                CLR1: begin
                    ap_rst              <= 1'b0;
                    ap_sel_internal_col <= 1'b0;
                    s_ready             <= 1'b1;
                    r_state             <= LOAD_A;
                end
                LOAD_A, LOAD_B: begin
                    if (w_beat) begin
                        ap_write_en         <= 1'b1;
                        ap_addr             <= r_count;
                        ap_data             <= s_data;
                        ap_sel_col          <= (r_state == LOAD_B);
                        ap_sel_internal_col <= 1'b0;
                        ap_mode             <= 1'b0;
                        if (r_count == LAST_CELL) begin
                            r_count <= '0;
                            if (r_state == LOAD_A) begin
                                r_state <= LOAD_B;
                            end else begin
                                s_ready <= 1'b0;
                                r_state <= COMPUTE;
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    ap_cmd  <= r_cmd;
                    ap_mode <= 1'b1;
                    r_timer <= TMR_LOAD;
                    r_state <= WAIT_IRQ;
                end
                WAIT_IRQ: begin
                    if (w_irq_rise) begin
                        ap_mode <= 1'b0;
                        r_count <= '0;
                        r_state <= READ_ISSUE;
                    end else if (r_timer == '0) begin
                        err     <= 1'b1;
                        ap_mode <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                READ_ISSUE: begin
                    ap_read_en          <= 1'b1;
                    ap_addr             <= r_count;
                    ap_sel_col          <= 1'b0;
                    ap_sel_internal_col <= 1'b1;
                    r_lat               <= LAT_LOAD;
                    r_state             <= READ_WAIT;
                end
                READ_WAIT: begin
                    if (r_lat == '0) begin
                        m_data  <= ap_data_out;
                        m_valid <= 1'b1;
                        r_state <= READ_HOLD;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                READ_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (r_count == LAST_CELL) begin
                            ap_sel_internal_col <= 1'b0;
                            done                <= 1'b1;
                            r_state             <= DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                            r_state <= READ_ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_loader.sv
// Directed bench for ap_loader with a small behavioural AP model whose
// read result at each address is column0 + column1.
module tb_ap_loader;

    localparam int WS = 8;
    localparam int CQ = 4;
    localparam int AW = 2;
    localparam int RL = 1;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cmd_in = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [WS-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [WS-1:0] m_data;
    logic          busy, done, err;
    logic [AW-1:0] ap_addr;
    logic [WS-1:0] ap_data;
    logic          ap_rst, ap_mode, ap_sel_col, ap_sel_internal_col;
    logic [2:0]    ap_cmd;
    logic          ap_write_en, ap_read_en;
    logic [WS-1:0] ap_data_out = '0;
    logic          ap_state_irq = 1'b0;

    always #5 clk = ~clk;

    ap_loader #(
        .WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW), .READ_LAT(RL), .TIMEOUT(TO)
    ) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done), .err(err),
        .ap_addr(ap_addr), .ap_data(ap_data), .ap_rst(ap_rst), .ap_mode(ap_mode),
        .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col), .ap_sel_internal_col(ap_sel_internal_col),
        .ap_write_en(ap_write_en), .ap_read_en(ap_read_en),
        .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq)
    );

    // AP model and activity logs, sampled mid-cycle.
    logic [WS-1:0]  mem [2][CQ];
    logic           rd_pend = 1'b0;
    logic [AW-1:0]  rd_a = '0;
    logic [10:0]    wr_log[$];
    logic [3:0]     rd_log[$];
    int             n_done = 0;
    int             n_beat = 0;

    always @(negedge clk) begin
        if (ap_write_en) begin
            mem[ap_sel_col][ap_addr] <= ap_data;
            wr_log.push_back({ap_sel_col, ap_addr, ap_data});
        end
        if (rd_pend) ap_data_out <= mem[0][rd_a] + mem[1][rd_a];
        rd_pend <= ap_read_en;
        rd_a    <= ap_addr;
        if (ap_read_en) rd_log.push_back({ap_addr, ap_sel_internal_col, ap_sel_col});
        if (done) n_done <= n_done + 1;
        if (s_valid && s_ready) n_beat <= n_beat + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, done, err, s_ready, m_valid, ap_rst, ap_mode, ap_write_en,
                ap_read_en, ap_sel_col, ap_sel_internal_col, ap_cmd, ap_addr, ap_data, m_data};
    endfunction

    task automatic start_job(input logic [2:0] c);
        start = 1'b1;
        cmd_in = c;
        tick();
        start = 1'b0;
        check("clr0_busy", busy, 1);
        check("clr0_err_clear", err, 0);
        check("clr0_rst", ap_rst, 1);
        check("clr0_int", ap_sel_internal_col, 0);
        tick();
        check("clr1_rst", ap_rst, 1);
        check("clr1_int", ap_sel_internal_col, 1);
        tick();
        check("loada_rst", ap_rst, 0);
        check("loada_int", ap_sel_internal_col, 0);
        check("loada_ready", s_ready, 1);
    endtask

    task automatic push(input logic [WS-1:0] d, input bit bubble, input int a, input bit col);
        int n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data = d;
        tick();
        s_valid = 1'b0;
        check("wr_en", ap_write_en, 1);
        check("wr_addr", ap_addr, a);
        check("wr_data", ap_data, d);
        check("wr_col", ap_sel_col, col);
        check("wr_mode", ap_mode, 0);
        if (bubble) begin
            tick();
            check("bubble_no_write", ap_write_en, 0);
        end
    endtask

    task automatic wait_mode(input logic [2:0] c);
        int n = 0;
        while (!ap_mode && n < 50) begin
            tick();
            n++;
        end
        check("mode_up", ap_mode, 1);
        check("ap_cmd", ap_cmd, c);
    endtask

    task automatic take(input logic [WS-1:0] exp, input int hold);
        int n = 0;
        int r0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        check("m_valid", m_valid, 1);
        check("m_data", m_data, exp);
        r0 = rd_log.size();
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, exp);
            check("hold_no_read", rd_log.size(), r0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("m_valid_drop", m_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int w0, d0, b0, r0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        check("idle_outs", all_outs(), 0);

        // Full job: A={1,2,3,4}, B={5,6,7,8}, cmd 3, irq 10 cycles into ap_mode
        start_job(3'd3);
        for (int i = 0; i < CQ; i++) push(WS'(i + 1), 1'b0, i, 1'b0);
        for (int i = 0; i < CQ; i++) push(WS'(i + 5), 1'b0, i, 1'b1);
        check("load_done_ready", s_ready, 0);
        wait_mode(3'd3);
        repeat (10) tick();
        check("mode_held", ap_mode, 1);
        ap_state_irq = 1'b1;
        tick();
        check("mode_drop_irq", ap_mode, 0);
        take(8'd6, 0);
        take(8'd8, 0);
        take(8'd10, 0);
        take(8'd12, 0);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        tick();
        check("done_low", done, 0);
        check("busy_low", busy, 0);
        check("err_ok", err, 0);
        check("n_done_job1", n_done, 1);
        check("n_wr_job1", wr_log.size(), 8);
        check("n_rd_job1", rd_log.size(), 4);
        for (int i = 0; i < CQ; i++) check("rd_seq", rd_log[i], {i[1:0], 2'b10});
        ap_state_irq = 1'b0;
        tick();

        // Bubbles on load and backpressure on result 2
        w0 = wr_log.size();
        b0 = n_beat;
        start_job(3'd1);
        push(8'd10, 1'b1, 0, 1'b0);
        push(8'd20, 1'b1, 1, 1'b0);
        push(8'd30, 1'b1, 2, 1'b0);
        push(8'd40, 1'b1, 3, 1'b0);
        push(8'd1, 1'b1, 0, 1'b1);
        push(8'd2, 1'b1, 1, 1'b1);
        push(8'd3, 1'b1, 2, 1'b1);
        push(8'd4, 1'b1, 3, 1'b1);
        wait_mode(3'd1);
        repeat (3) tick();
        ap_state_irq = 1'b1;
        tick();
        ap_state_irq = 1'b0;
        take(8'd11, 0);
        take(8'd22, 5);
        take(8'd33, 0);
        take(8'd44, 0);
        tick();
        check("n_wr_job2", wr_log.size() - w0, 8);
        check("n_beat_job2", n_beat - b0, 8);
        check("n_done_job2", n_done, 2);

        // Timeout: irq never rises
        r0 = rd_log.size();
        start_job(3'd2);
        for (int i = 0; i < CQ; i++) push(WS'(i), 1'b0, i, 1'b0);
        for (int i = 0; i < CQ; i++) push(WS'(i), 1'b0, i, 1'b1);
        wait_mode(3'd2);
        k = 0;
        while (!err && k < 40) begin
            tick();
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_err", err, 1);
        check("timeout_mode", ap_mode, 0);
        check("timeout_done", done, 1);
        tick();
        check("timeout_done_low", done, 0);
        check("timeout_busy_low", busy, 0);
        check("timeout_err_sticky", err, 1);
        check("timeout_no_read", rd_log.size(), r0);
        check("n_done_job3", n_done, 3);

        // Pre-high irq and start during busy
        ap_state_irq = 1'b1;
        tick();
        start_job(3'd6);
        push(8'd7, 1'b0, 0, 1'b0);
        push(8'd9, 1'b0, 1, 1'b0);
        start = 1'b1;
        cmd_in = 3'd5;
        tick();
        start = 1'b0;
        check("ignored_start_busy", busy, 1);
        check("ignored_start_ready", s_ready, 1);
        check("ignored_start_rst", ap_rst, 0);
        push(8'd11, 1'b0, 2, 1'b0);
        push(8'd13, 1'b0, 3, 1'b0);
        for (int i = 0; i < CQ; i++) push(8'd1, 1'b0, i, 1'b1);
        wait_mode(3'd6);
        repeat (8) tick();
        check("prehigh_no_exit", ap_mode, 1);
        ap_state_irq = 1'b0;
        tick();
        ap_state_irq = 1'b1;
        tick();
        check("fresh_edge_exit", ap_mode, 0);
        check("fresh_edge_err", err, 0);
        take(8'd8, 0);
        take(8'd10, 0);
        take(8'd12, 0);
        take(8'd14, 0);
        tick();
        check("n_done_job4", n_done, 4);
        ap_state_irq = 1'b0;

        // Reset in the middle of LOAD_B
        start_job(3'd4);
        for (int i = 0; i < CQ; i++) push(WS'(i), 1'b0, i, 1'b0);
        push(8'd1, 1'b0, 0, 1'b1);
        push(8'd2, 1'b0, 1, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midload_reset_outs", all_outs(), 0);
        w0 = wr_log.size();
        d0 = n_done;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_no_write", wr_log.size(), w0);
        check("post_reset_no_done", n_done, d0);
        check("post_reset_idle", all_outs(), 0);
        start_job(3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
